serial_alu_unit: RTL and testbench

//  Execution-side consumer of the 4-bit ALU Operation code produced by the ALU controller.

---
 rtl/serial_alu_unit.sv | 95 +++++++++
 tb/tb_serial_alu_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/serial_alu_unit.sv
// serial_alu_unit: digit-serial ALU with valid/ready request and result handshakes
module serial_alu_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Bad_Op
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_n;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_n, fin;
  logic [CW-1:0]    cnt;
  logic             carry, last, s, v;
  logic             is_and, is_or, is_add, is_sub, is_slt, is_nor, bad;
  logic [DIGIT-1:0] ad, bd, dig;
  logic [DIGIT:0]   sum;
  assign is_and = op_q == 4'b0000;
  assign is_or  = op_q == 4'b0001;
  assign is_add = op_q == 4'b0010;
  assign is_sub = op_q == 4'b0110;
  assign is_slt = op_q == 4'b0111;
  assign is_nor = op_q == 4'b1100;
  assign bad    = !(is_and | is_or | is_add | is_sub | is_slt | is_nor);
  assign last   = cnt == CW'(N - 1);
  // Subtraction is A + ~B with carry-in seeded to 1 at accept time.
  assign ad  = a_q[cnt*DIGIT +: DIGIT];
  assign bd  = b_q[cnt*DIGIT +: DIGIT] ^ {DIGIT{is_sub | is_slt}};
  assign sum = {1'b0, ad} + {1'b0, bd} + {{DIGIT{1'b0}}, carry};
  assign dig = is_and ? ad & bd : is_or ? ad | bd : is_nor ? ~(ad | bd) : sum[DIGIT-1:0];
  always_comb begin
    acc_n = acc;
    acc_n[cnt*DIGIT +: DIGIT] = dig;
  end
  assign s   = acc_n[WIDTH-1];
  assign v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (s != a_q[WIDTH-1]);
  assign fin = is_slt ? WIDTH'(s ^ v) : acc_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = In_Valid ? EXEC : IDLE;
      EXEC:    state_n = last ? DONE : EXEC;
      DONE:    state_n = Out_Ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    In_Ready  = state == IDLE;
    Out_Valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      Result <= '0;
      Zero   <= 1'b0;
      Bad_Op <= 1'b0;
    end else if (state == IDLE && In_Valid) begin
      op_q  <= Operation;
      a_q   <= A;
      b_q   <= B;
      acc   <= '0;
      cnt   <= '0;
      carry <= Operation == 4'b0110 || Operation == 4'b0111;
    end else if (state == EXEC) begin
      acc   <= acc_n;
      carry <= sum[DIGIT];
      cnt   <= cnt + 1'b1;
      if (last) begin
        Result <= fin;
        Zero   <= fin == '0;
        Bad_Op <= bad;
      end
    end
  end
endmodule

// File: tb/tb_serial_alu_unit.sv
// tb_serial_alu_unit: directed vectors run on DIGIT=4, 1 and 32 instances in lockstep
module tb_serial_alu_unit;
  logic clk = 0, rst_n = 0, In_Valid = 0, Out_Ready = 0;
  logic [3:0] Operation = '0;
  logic [31:0] A = '0, B = '0;
  logic [2:0] ir, ov, zr, bo;
  logic [31:0] r0, r1, r2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  serial_alu_unit #(.WIDTH(32), .DIGIT(4)) u0 (.clk(clk), .rst_n(rst_n), .In_Valid(In_Valid), .In_Ready(ir[0]),
    .Operation(Operation), .A(A), .B(B), .Out_Valid(ov[0]), .Out_Ready(Out_Ready), .Result(r0), .Zero(zr[0]), .Bad_Op(bo[0]));
  serial_alu_unit #(.WIDTH(32), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .In_Valid(In_Valid), .In_Ready(ir[1]),
    .Operation(Operation), .A(A), .B(B), .Out_Valid(ov[1]), .Out_Ready(Out_Ready), .Result(r1), .Zero(zr[1]), .Bad_Op(bo[1]));
  serial_alu_unit #(.WIDTH(32), .DIGIT(32)) u2 (.clk(clk), .rst_n(rst_n), .In_Valid(In_Valid), .In_Ready(ir[2]),
    .Operation(Operation), .A(A), .B(B), .Out_Valid(ov[2]), .Out_Ready(Out_Ready), .Result(r2), .Zero(zr[2]), .Bad_Op(bo[2]));
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic        z, bd;
  } vec_t;
  vec_t vt[14];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  task automatic run_op(input vec_t t);
    int l0 = 0, l1 = 0, l2 = 0;
    @(negedge clk);
    Operation = t.op; A = t.a; B = t.b; In_Valid = 1;
    chk("in_ready_idle", 32'(ir), 32'h7);
    @(negedge clk);
    In_Valid = 0; A = ~t.a; B = ~t.b; Operation = 4'b0001;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ov[0] && l0 == 0) l0 = k;
      if (ov[1] && l1 == 0) l1 = k;
      if (ov[2] && l2 == 0) l2 = k;
    end
    chk("latency_d4", 32'(l0), 32'd8);
    chk("latency_d1", 32'(l1), 32'd32);
    chk("latency_d32", 32'(l2), 32'd1);
    chk("result_d4", r0, t.r);
    chk("result_d1", r1, t.r);
    chk("result_d32", r2, t.r);
    chk("zero", 32'(zr), {29'd0, {3{t.z}}});
    chk("bad_op", 32'(bo), {29'd0, {3{t.bd}}});
  endtask
  task automatic release_out;
    @(negedge clk);
    Out_Ready = 1;
    @(negedge clk);
    Out_Ready = 0;
    chk("back_to_idle", {30'd0, ov[0], ir[0]}, 32'h1);
  endtask
  initial begin
    vt[0]  = '{4'b0010, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0};
    vt[1]  = '{4'b0110, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0};
    vt[2]  = '{4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[3]  = '{4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vt[4]  = '{4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vt[5]  = '{4'b0111, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vt[6]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vt[7]  = '{4'b0001, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 1'b0, 1'b0};
    vt[8]  = '{4'b1100, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 1'b0, 1'b0};
    vt[9]  = '{4'b1111, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b1};
    vt[10] = '{4'b0011, 32'h0000000A, 32'h00000014, 32'h0000001E, 1'b0, 1'b1};
    vt[11] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vt[12] = '{4'b0111, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 1'b0};
    vt[13] = '{4'b0110, 32'h12345678, 32'h02345679, 32'h0FFFFFFF, 1'b0, 1'b0};
    #3;
    chk("rst_result", r0, 32'h0);
    chk("rst_flags", {28'd0, zr[0], bo[0], ov[0], ir[0]}, 32'h1);
    @(negedge clk);
    rst_n = 1;
    foreach (vt[i]) begin
      run_op(vt[i]);
      release_out();
    end
    // Backpressure: result held while a competing request waits.
    run_op('{4'b0010, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0});
    Operation = 4'b0001; A = 32'h1; B = 32'h2; In_Valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_result", r0, 32'h12345678);
      chk("hold_valid_ready", {30'd0, ov[0], ir[0]}, 32'h2);
    end
    In_Valid = 0;
    release_out();
    run_op('{4'b0001, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0});
    release_out();
    // Reset during beat 3 of an op.
    @(negedge clk);
    Operation = 4'b0010; A = 32'h5; B = 32'h3; In_Valid = 1;
    @(negedge clk);
    In_Valid = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_valid_ready", {29'd0, ov[0], ov[2], ir[0]}, 32'h1);
    chk("abort_result_d4", r0, 32'h0);
    chk("abort_result_d32", r2, 32'h0);
    @(negedge clk);
    rst_n = 1;
    run_op('{4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0});
    release_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
